turn_scheduler: RTL

TURN_SCHEDULER -- requirements
Module: turn_scheduler

---
 rtl/chicken_pkg.sv | 47 ++++
 rtl/turn_scheduler_if.sv | 53 +++++
 rtl/turn_scheduler_phase_timer.sv | 40 ++++
 rtl/turn_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/chicken_pkg.sv
// chicken_pkg -- shared definitions for the turn scheduler.
//
// Holds the scheduler state enumeration, the player-index and streak widths,
// the maximum player count, and two small helpers used when decoding the
// player count and rotating the turn.
//
// No ports (package).

package chicken_pkg;

  // Up to four players; the player index and the num_players field are both
  // sized from this.
  localparam int MAX_PLAYERS = 4;
  localparam int PLAYER_W    = $clog2(MAX_PLAYERS);

  // Consecutive-match streak counter width; it saturates at all ones (31).
  localparam int                  STREAK_W   = 5;
  localparam logic [STREAK_W-1:0] STREAK_MAX = {STREAK_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PICK   = 3'd1,
    ST_REVEAL = 3'd2,
    ST_MOVE   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_PASS   = 3'd5,
    ST_OVER   = 3'd6
  } state_t;

  // num_players carries (player count - 1). A value of 0 would mean a
  // one-player game, which makes no sense, so it is treated as two players.
  // The result is the index of the last player in the rotation.
  function automatic logic [PLAYER_W-1:0] last_player(
    input logic [PLAYER_W-1:0] num_players
  );
    return (num_players == '0) ? PLAYER_W'(1) : num_players;
  endfunction

  // Round-robin successor, wrapping after the last active player.
  function automatic logic [PLAYER_W-1:0] next_player(
    input logic [PLAYER_W-1:0] cur,
    input logic [PLAYER_W-1:0] last
  );
    return (cur == last) ? '0 : cur + 1'b1;
  endfunction

endpackage

// File: rtl/turn_scheduler_if.sv
// turn_scheduler_if -- signal bundle between the game logic and the turn
// scheduler.
//
// Handshake semantics: there is no valid/ready back-pressure on this bus.
// start and B are single-cycle strobes; the scheduler acts on a strobe only
// in the state that accepts it (start in IDLE/OVER, B in PICK) and silently
// drops it anywhere else. tile_match is qualified by B, and W is only looked
// at during the single CHECK cycle. All scheduler outputs are registered.
//
// Signals:
//   start       game logic -> scheduler  begin a new game
//   num_players game logic -> scheduler  player count minus 1
//   B           game logic -> scheduler  pick strobe from current player
//   tile_match  game logic -> scheduler  picked tile matches (with B)
//   W           game logic -> scheduler  win flag from the win checker
//   T           scheduler  -> game logic current player index
//   N           scheduler  -> game logic current player's match streak
//   move_en     scheduler  -> game logic one-cycle advance strobe
//   reveal      scheduler  -> game logic high during the reveal phase
//   game_over   scheduler  -> game logic high in OVER
//   winner      scheduler  -> game logic player index latched on win
//   timeout     scheduler  -> game logic one-cycle pick-timeout strobe
//
// Modports: master = game logic side, slave = scheduler side.

interface turn_scheduler_if;
  import chicken_pkg::*;

  logic                start;
  logic [PLAYER_W-1:0] num_players;
  logic                B;
  logic                tile_match;
  logic                W;

  logic [PLAYER_W-1:0] T;
  logic [STREAK_W-1:0] N;
  logic                move_en;
  logic                reveal;
  logic                game_over;
  logic [PLAYER_W-1:0] winner;
  logic                timeout;

  modport master (
    output start, num_players, B, tile_match, W,
    input  T, N, move_en, reveal, game_over, winner, timeout
  );

  modport slave (
    input  start, num_players, B, tile_match, W,
    output T, N, move_en, reveal, game_over, winner, timeout
  );

endinterface

// File: rtl/turn_scheduler_phase_timer.sv
// phase_timer -- loadable down-counter with a done flag.
//
// The scheduler shares one instance between the reveal hold and (when
// enabled) the pick timeout, since the two phases never overlap.
// Loading value V makes done rise V cycles later, so a phase that must last
// L cycles is loaded with L-1 on the edge that enters it. The counter parks
// at zero once it gets there.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset (clears the count)
//   load     in   load load_val on the next edge (wins over counting)
//   load_val in   W-bit reload value
//   done     out  count is zero

module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler -- turn sequencing for a multi-player tile-matching game.
//
// Flow per turn: PICK waits for the current player's pick strobe B; REVEAL
// holds the picked tile visible for REVEAL_CYCLES cycles; a match goes to
// MOVE (one move_en strobe, streak +1 saturating at 31) and CHECK (win test,
// otherwise the same player picks again); a mismatch goes to PASS (streak
// cleared, turn handed to the next player). A win latches the winner and
// parks in OVER until the next start.
//
// Optional feature, macro TURN_TIMEOUT_EN: when defined, PICK is bounded by
// TIMEOUT_CYCLES; a player who has not picked by then gets a timeout strobe
// and loses the turn as if it were a mismatch. When undefined, PICK waits
// forever and timeout is held at 0.
//
// Parameters:
//   REVEAL_CYCLES  cycles reveal is held (>= 1)
//   TIMEOUT_CYCLES pick timeout length (>= 1), only used with TURN_TIMEOUT_EN
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-low reset
//   bus       slave side of turn_scheduler_if (see that file)
//   state_dbg out  current FSM state, for observation only

module turn_scheduler
  import chicken_pkg::*;
#(
  parameter int REVEAL_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  turn_scheduler_if.slave  bus,
  output state_t           state_dbg
);

  // The shared timer is sized for the longest phase it has to time.
`ifdef TURN_TIMEOUT_EN
  localparam int TIMER_MAX = (TIMEOUT_CYCLES > REVEAL_CYCLES) ? TIMEOUT_CYCLES
                                                              : REVEAL_CYCLES;
`else
  localparam int TIMER_MAX = REVEAL_CYCLES;
`endif
  localparam int          TW          = $clog2(TIMER_MAX + 1);
  localparam logic [TW-1:0] REVEAL_LOAD = TW'(REVEAL_CYCLES - 1);

  state_t              state;
  logic [PLAYER_W-1:0] last_idx;    // index of last player, latched at start
  logic [PLAYER_W-1:0] turn;
  logic [STREAK_W-1:0] streak;
  logic                match_q;     // tile_match captured with B
  logic                move_en_q;
  logic                reveal_q;
  logic                game_over_q;
  logic [PLAYER_W-1:0] winner_q;
  logic                timeout_q;

  logic                pick_ok;
  logic                timer_load;
  logic [TW-1:0]       timer_val;
  logic                timer_done;

  assign pick_ok = bus.B && (state == ST_PICK);

`ifdef TURN_TIMEOUT_EN
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

  // Every edge that lands the FSM in PICK restarts the timeout window.
  logic pick_entry;
  assign pick_entry = (bus.start && (state == ST_IDLE || state == ST_OVER)) ||
                      (state == ST_CHECK && !bus.W) ||
                      (state == ST_PASS);
`else
  // No timeout path exists in this build; the parameter only keeps the
  // instantiation interface identical between builds.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    timer_load = 1'b0;
    timer_val  = REVEAL_LOAD;
    if (pick_ok) begin
      timer_load = 1'b1;
      timer_val  = REVEAL_LOAD;
    end
`ifdef TURN_TIMEOUT_EN
    else if (pick_entry) begin
      timer_load = 1'b1;
      timer_val  = TIMEOUT_LOAD;
    end
`endif
  end

  phase_timer #(
    .W (TW)
  ) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // Outputs are registered alongside the state, so each strobe is set on
  // the same edge that enters the state it belongs to. move_en, reveal and
  // timeout default low every cycle and are each set in a different branch,
  // so at most one of them is high at a time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      last_idx    <= PLAYER_W'(1);
      turn        <= '0;
      streak      <= '0;
      match_q     <= 1'b0;
      move_en_q   <= 1'b0;
      reveal_q    <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      move_en_q <= 1'b0;
      reveal_q  <= 1'b0;
      timeout_q <= 1'b0;

      case (state)
        ST_IDLE, ST_OVER: begin
          if (bus.start) begin
            last_idx    <= last_player(bus.num_players);
            turn        <= '0;
            streak      <= '0;
            game_over_q <= 1'b0;
            state       <= ST_PICK;
          end
        end

        ST_PICK: begin
          // A pick on the expiry cycle still counts as a pick.
          if (bus.B) begin
            match_q  <= bus.tile_match;
            reveal_q <= 1'b1;
            state    <= ST_REVEAL;
          end
`ifdef TURN_TIMEOUT_EN
          else if (timer_done) begin
            timeout_q <= 1'b1;
            state     <= ST_PASS;
          end
`endif
        end

        ST_REVEAL: begin
          if (timer_done) begin
            if (match_q) begin
              move_en_q <= 1'b1;
              state     <= ST_MOVE;
            end else begin
              state <= ST_PASS;
            end
          end else begin
            reveal_q <= 1'b1;
          end
        end

        ST_MOVE: begin
          if (streak != STREAK_MAX) begin
            streak <= streak + 1'b1;
          end
          state <= ST_CHECK;
        end

        ST_CHECK: begin
          if (bus.W) begin
            winner_q    <= turn;
            game_over_q <= 1'b1;
            state       <= ST_OVER;
          end else begin
            state <= ST_PICK;
          end
        end

        ST_PASS: begin
          streak <= '0;
          turn   <= next_player(turn, last_idx);
          state  <= ST_PICK;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.T         = turn;
  assign bus.N         = streak;
  assign bus.move_en   = move_en_q;
  assign bus.reveal    = reveal_q;
  assign bus.game_over = game_over_q;
  assign bus.winner    = winner_q;
  assign bus.timeout   = timeout_q;
  assign state_dbg     = state;

endmodule
